// File: rtl/udc_counter_if.sv
// udc_counter_if: control and status bundle for udc_counter.
// master drives the count controls, slave is the counter itself.
interface udc_counter_if #(
  parameter int WIDTH = 3
);
  logic             udc_en;
  logic             udc_up;
  logic             udc_clr;
  logic             udc_load;
  logic [WIDTH-1:0] udc_load_val;
  logic [WIDTH-1:0] udc_out;
  logic             udc_tc;
  logic             udc_zero;

  modport master (
    output udc_en, udc_up, udc_clr, udc_load, udc_load_val,
    input  udc_out, udc_tc, udc_zero
  );

  modport slave (
    input  udc_en, udc_up, udc_clr, udc_load, udc_load_val,
    output udc_out, udc_tc, udc_zero
  );
endinterface

// File: rtl/udc_counter.sv
// udc_counter: parametrised up/down counter with modulus MAX_COUNT+1,
// priority clr > load > en, clamped parallel load, registered terminal-count
// pulse and combinational zero flag.
// Build option: define UDC_SATURATE_EN to hold at the limits instead of wrapping.
module udc_counter #(
  parameter int WIDTH     = 3,
  parameter int MAX_COUNT = (1 << WIDTH) - 1
) (
  input  logic          udc_clk,
  input  logic          udc_rst_n,
  udc_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;

  // Next count and terminal-event detection; a blocked or wrapped step is the terminal event.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (bus.udc_clr) begin
      cnt_d = '0;
    end else if (bus.udc_load) begin
      cnt_d = (bus.udc_load_val > MAX_V) ? MAX_V : bus.udc_load_val;
    end else if (bus.udc_en) begin
      if (bus.udc_up) begin
        if (cnt_q == MAX_V) begin
          tc_d = 1'b1;
`ifdef UDC_SATURATE_EN
          cnt_d = MAX_V;
`else
          cnt_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + ONE_V;
        end
      end else begin
        if (cnt_q == '0) begin
          tc_d = 1'b1;
`ifdef UDC_SATURATE_EN
          cnt_d = '0;
`else
          cnt_d = MAX_V;
`endif
        end else begin
          cnt_d = cnt_q - ONE_V;
        end
      end
    end
  end

  // Count and terminal-count registers, cleared asynchronously.
  always_ff @(posedge udc_clk or negedge udc_rst_n) begin
    if (!udc_rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign bus.udc_out  = cnt_q;
  assign bus.udc_tc   = tc_q;
  assign bus.udc_zero = (cnt_q == '0);

endmodule

// File: tb/tb_udc_counter.sv
// tb_udc_counter: directed scenarios plus randomized traffic for udc_counter,
// checked against an arithmetic reference model of the counting rules.
module tb_udc_counter;

  localparam int WIDTH = 3;
`ifdef UDC_SATURATE_EN
  localparam int MAXC = 7;
`else
  localparam int MAXC = 5;
`endif

  logic udc_clk;
  logic udc_rst_n;

  udc_counter_if #(.WIDTH(WIDTH)) bus ();

  udc_counter #(.WIDTH(WIDTH), .MAX_COUNT(MAXC)) dut (
    .udc_clk   (udc_clk),
    .udc_rst_n (udc_rst_n),
    .bus       (bus)
  );

  initial udc_clk = 1'b0;
  always #5 udc_clk = ~udc_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_cnt = 0;
  int m_tc  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference behaviour: priority clr > load > en, modulus MAXC+1 or saturation.
  task automatic model_edge(input int en, input int up, input int clr, input int ld, input int lv);
    if (clr != 0) begin
      m_cnt = 0; m_tc = 0;
    end else if (ld != 0) begin
      m_cnt = (lv > MAXC) ? MAXC : lv; m_tc = 0;
    end else if (en != 0) begin
      if (up != 0) begin
        m_tc = (m_cnt == MAXC) ? 1 : 0;
`ifdef UDC_SATURATE_EN
        m_cnt = (m_cnt == MAXC) ? MAXC : m_cnt + 1;
`else
        m_cnt = (m_cnt + 1) % (MAXC + 1);
`endif
      end else begin
        m_tc = (m_cnt == 0) ? 1 : 0;
`ifdef UDC_SATURATE_EN
        m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
`else
        m_cnt = (m_cnt + MAXC) % (MAXC + 1);
`endif
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out"},  int'(bus.udc_out),  m_cnt);
    chk({tag, ".tc"},   int'(bus.udc_tc),   m_tc);
    chk({tag, ".zero"}, int'(bus.udc_zero), (m_cnt == 0) ? 1 : 0);
  endtask

  // Drive one cycle's controls at the falling edge, advance one rising edge, check at the next falling edge.
  task automatic step(input string tag, input int en, input int up, input int clr, input int ld, input int lv);
    bus.udc_en       = 1'(en);
    bus.udc_up       = 1'(up);
    bus.udc_clr      = 1'(clr);
    bus.udc_load     = 1'(ld);
    bus.udc_load_val = WIDTH'(lv);
    @(posedge udc_clk);
    if (udc_rst_n) model_edge(en, up, clr, ld, lv);
    @(negedge udc_clk);
    check_outputs(tag);
  endtask

  initial begin
    udc_rst_n        = 1'b0;
    bus.udc_en       = 1'b0;
    bus.udc_up       = 1'b0;
    bus.udc_clr      = 1'b0;
    bus.udc_load     = 1'b0;
    bus.udc_load_val = '0;
    repeat (2) @(negedge udc_clk);
    check_outputs("reset");
    udc_rst_n = 1'b1;

    // Count to 5, then assert reset between edges.
    for (int i = 0; i < 5; i++) step("cnt5", 1, 1, 0, 0, 0);
    chk("cnt5.value", int'(bus.udc_out), 5);
    #2 udc_rst_n = 1'b0;
    m_cnt = 0; m_tc = 0;
    #1 check_outputs("async_rst");
    for (int i = 0; i < 3; i++) step("rst_hold", 1, 1, 0, 0, 0);
    udc_rst_n = 1'b1;
    step("rst_release", 1, 1, 0, 0, 0);
    chk("rst_release.first", int'(bus.udc_out), 1);

`ifndef UDC_SATURATE_EN
    step("clr0", 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step("upwrap", 1, 1, 0, 0, 0);
    chk("upwrap.final", int'(bus.udc_out), 2);
    step("clr1", 0, 0, 1, 0, 0);
    step("downwrap0", 1, 0, 0, 0, 0);
    chk("downwrap.first", int'(bus.udc_out), 5);
    chk("downwrap.tc", int'(bus.udc_tc), 1);
    step("downwrap1", 1, 0, 0, 0, 0);
    step("downwrap2", 1, 0, 0, 0, 0);
    step("prio_all", 1, 1, 1, 1, 3);
    chk("prio_all.value", int'(bus.udc_out), 0);
    step("clamp_load", 1, 1, 0, 1, 7);
    chk("clamp_load.value", int'(bus.udc_out), 5);
    step("clamp_wrap", 1, 1, 0, 0, 0);
    chk("clamp_wrap.tc", int'(bus.udc_tc), 1);
    step("load4", 0, 0, 0, 1, 4);
    for (int i = 0; i < 4; i++) step("hold", 0, 1, 0, 0, 0);
    chk("hold.value", int'(bus.udc_out), 4);
`else
    step("sat_load6", 0, 0, 0, 1, 6);
    for (int i = 0; i < 3; i++) step("sat_up", 1, 1, 0, 0, 0);
    chk("sat_up.value", int'(bus.udc_out), 7);
    chk("sat_up.tc", int'(bus.udc_tc), 1);
    step("sat_load1", 0, 0, 0, 1, 1);
    step("sat_down0", 1, 0, 0, 0, 0);
    chk("sat_down0.tc", int'(bus.udc_tc), 0);
    step("sat_down1", 1, 0, 0, 0, 0);
    chk("sat_down1.value", int'(bus.udc_out), 0);
    chk("sat_down1.tc", int'(bus.udc_tc), 1);
`endif

    // Randomized traffic with an occasional asynchronous reset pulse.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2 udc_rst_n = 1'b0;
        m_cnt = 0; m_tc = 0;
        #1 check_outputs("rand_rst");
        @(negedge udc_clk);
        udc_rst_n = 1'b1;
      end
      step("rand",
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           int'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0) ? 1 : 0,
           ($urandom_range(0, 7) == 0) ? 1 : 0,
           int'($urandom_range(0, (1 << WIDTH) - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/udc_counter.md
# udc_counter

Parametrised up/down counter: next-generation replacement for the fixed 3-bit free-running up counter. Adds configurable width and modulus, count enable, direction control, synchronous clear, parallel load, a registered terminal-count pulse and an active-low asynchronous reset. It serves as the shared counting primitive for sequencers, dividers and address generators in the design.

## Interface
- `WIDTH`, default 3: counter width in bits; must be ≥ 1.
- `MAX_COUNT`, default `2**WIDTH-1`: terminal (highest) count value; legal range 1 … `2**WIDTH-1`.

- `udc_clk`, in, 1: clock; all state updates on its rising edge.
- `udc_rst_n`, in, 1: reset, asynchronous, active-low.
- `udc_en`, in, 1: count enable; one step per enabled cycle.
- `udc_up`, in, 1: direction; 1 = increment, 0 = decrement.
- `udc_clr`, in, 1: synchronous clear to 0.
- `udc_load`, in, 1: synchronous parallel load.
- `udc_load_val`, in, WIDTH: value to load.
- `udc_out`, out, WIDTH: registered count value.
- `udc_tc`, out, 1: registered terminal-count pulse.
- `udc_zero`, out, 1: combinational flag, high when `udc_out == 0`.

## Operation
- Reset (`udc_rst_n` low, asynchronous):
  - `udc_out` = 0 and `udc_tc` = 0 immediately, independent of the clock.
  - State is held for as long as `udc_rst_n` stays low.
  - Reset asserted mid-count discards the count.
- Per rising edge, priority `udc_clr` > `udc_load` > `udc_en`:
  - **clr:** `udc_out` ← 0, `udc_tc` ← 0.
  - **load:** `udc_out` ← `udc_load_val`; if `udc_load_val` > `MAX_COUNT`, load `MAX_COUNT` instead (clamped). `udc_tc` ← 0.
  - **en, up:**
    - If `udc_out` < `MAX_COUNT`: `udc_out` + 1.
    - If `udc_out` == `MAX_COUNT`: terminal event, `udc_out` ← 0 (wrap).
  - **en, down:**
    - If `udc_out` > 0: `udc_out` − 1.
    - If `udc_out` == 0: terminal event, `udc_out` ← `MAX_COUNT` (wrap).
  - **Idle** (none asserted): `udc_out` holds, `udc_tc` ← 0.
- `udc_tc` ← 1 on exactly the edge that processes a terminal event, and 0 on every other edge. It is a single-cycle pulse per event; consecutive terminal events produce consecutive pulses.
- Arithmetic:
  - Performed at WIDTH bits; no carry leaves the block.
  - `udc_out` never exceeds `MAX_COUNT`.
  - The modulus is `MAX_COUNT+1` in wrap mode.
- `udc_up` may change on any cycle; the direction applies to the same edge it is sampled on.
- When `udc_clr` or `udc_load` coincides with `udc_en`, the count step is dropped and no terminal event occurs.

## Timing
- Latency from input to `udc_out`: 1 cycle (registered); no pipelining.
- `udc_tc` is valid in the same cycle as the `udc_out` value produced by the terminal step (e.g. `udc_out` = 0 and `udc_tc` = 1 together after an up-wrap).
- `udc_zero` follows `udc_out` combinationally, with zero added latency.
- Reset release: the first count step occurs on the first rising edge at which `udc_rst_n` is high and `udc_en` = 1.
- Throughput: one step per cycle maximum.

## Configuration
- Macro: `UDC_SATURATE_EN`.
- **Defined:** saturating mode.
  - Up at `MAX_COUNT` holds `MAX_COUNT`; down at 0 holds 0.
  - The blocked step still counts as a terminal event, so `udc_tc` pulses for each enabled cycle spent at the limit in the current direction.
- **Undefined (default):** wrap mode as described in Operation.
- All other behaviour (priority, clamped load, reset, flags) is identical in both modes.

## Test plan
- **Reset:** count to 5, assert `udc_rst_n` low between clock edges → `udc_out` = 0 and `udc_tc` = 0 before the next edge; hold low for 3 cycles with `udc_en` = 1 → stays 0.
- **Up-wrap** (WIDTH=3, MAX_COUNT=5, wrap): `udc_en` = 1, `udc_up` = 1 for 8 cycles from 0 → 1,2,3,4,5,0,1,2; `udc_tc` = 1 only with the first 0.
- **Down-wrap** (same parameters): from 0, `udc_up` = 0 for 3 cycles → 5,4,3; `udc_tc` = 1 with the 5.
- **Priority and clamp:** `udc_clr`, `udc_load` (val 3) and `udc_en` all high → 0. Then `udc_load` with val 7 plus `udc_en` → 5, `udc_tc` = 0. Then `udc_en` alone, up → 0 with `udc_tc` = 1.
- **Hold:** at value 4, deassert all controls for 4 cycles → `udc_out` stays 4 and `udc_tc` stays 0; `udc_zero` is 1 only when `udc_out` = 0.
- **`UDC_SATURATE_EN` defined** (WIDTH=3, MAX_COUNT=7): up from 6 for 3 cycles → 7,7,7 with `udc_tc` = 0,1,1; then down from 1 for 2 cycles → 0,0 with `udc_tc` = 0,1.
